// File: rtl/alu_handshake_unit_if.sv
// Request/response bus of the handshaked ALU.
// master drives operations and takes responses; slave is the ALU itself.
interface alu_handshake_unit_if #(
  parameter int unsigned N = 64
);
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   ALUControl;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] result;
  logic         zero;
  logic         busy;

  modport master (
    output req_valid, ALUControl, a, b, rsp_ready,
    input  req_ready, rsp_valid, result, zero, busy
  );

  modport slave (
    input  req_valid, ALUControl, a, b, rsp_ready,
    output req_ready, rsp_valid, result, zero, busy
  );
endinterface

// File: rtl/alu_handshake_unit.sv
// Handshaked ALU: single-cycle logic/arithmetic ops plus an N-step shift-add multiply.
// The result is held in DONE until the consumer takes it.
module alu_handshake_unit #(
  parameter int unsigned N = 64
) (
  input  logic               clk,
  input  logic               reset,
  alu_handshake_unit_if.slave bus
);
  localparam int unsigned CW = $clog2(N) + 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_PASB = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    result_q, result_d;
  logic            zero_q, zero_d;
  logic [N-1:0]    mcand_q, mcand_d;
  logic [N-1:0]    mplier_q, mplier_d;
  logic [N-1:0]    acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            req_ready_q, rsp_valid_q, busy_q;
  logic [N-1:0]    alu_res;
  logic [N-1:0]    step_sum;

  // Single-cycle operation result; undefined opcodes yield zero.
  always_comb begin
    alu_res = '0;
    case (bus.ALUControl)
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_ADD:  alu_res = bus.a + bus.b;
      OP_SUB:  alu_res = bus.a - bus.b;
      OP_PASB: alu_res = bus.b;
      OP_NOR:  alu_res = ~(bus.a | bus.b);
      default: alu_res = '0;
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (bus.ALUControl == OP_MUL) begin
            state_d  = MUL;
            mcand_d  = bus.a;
            mplier_d = bus.b;
            acc_d    = '0;
            cnt_d    = CW'(N);
          end else begin
            state_d  = DONE;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
          end
        end
      end
      MUL: begin
        acc_d    = step_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        // The last step lands directly in the result register.
        if (cnt_q == CW'(1)) begin
          state_d  = DONE;
          result_d = step_sum;
          zero_d   = (step_sum == '0);
        end
      end
      DONE: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      result_q    <= '0;
      zero_q      <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      req_ready_q <= (state_d == IDLE);
      rsp_valid_q <= (state_d == DONE);
      busy_q      <= (state_d == MUL);
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.busy      = busy_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_alu_handshake_unit.sv
// Directed bench for alu_handshake_unit: single ops, multiply timing, backpressure, async reset.
module tb_alu_handshake_unit;
  localparam int unsigned N = 64;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  alu_handshake_unit_if #(.N(N)) bus ();

  alu_handshake_unit #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Offers one request for exactly one edge; returns #1 after that edge.
  task automatic send(input logic [3:0] op, input logic [N-1:0] av, input logic [N-1:0] bv);
    bus.req_valid  = 1'b1;
    bus.ALUControl = op;
    bus.a          = av;
    bus.b          = bv;
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
  endtask

  task automatic consume();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.req_valid = 1'b0; bus.rsp_ready = 1'b0;
    bus.ALUControl = 4'h0; bus.a = '0; bus.b = '0;
    #12;
    tests++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.result !== 64'h0 || bus.zero !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: rdy=%b vld=%b busy=%b res=%h zero=%b, want 1 0 0 0 0",
               bus.req_ready, bus.rsp_valid, bus.busy, bus.result, bus.zero);
    end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_add();
    send(4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1);
    tests++;
    if (bus.rsp_valid !== 1'b1 || bus.result !== 64'h8000_0000_0000_0000 || bus.zero !== 1'b0) begin
      fails++;
      $display("FAIL add_overflow: vld=%b res=%h zero=%b, want 1 8000000000000000 0",
               bus.rsp_valid, bus.result, bus.zero);
    end
    consume();
    tests++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL add_release: rdy=%b vld=%b, want 1 0", bus.req_ready, bus.rsp_valid);
    end
  endtask

  task automatic test_sub();
    send(4'b0110, 64'd5, 64'd5);
    tests++;
    if (bus.rsp_valid !== 1'b1 || bus.result !== 64'h0 || bus.zero !== 1'b1) begin
      fails++;
      $display("FAIL sub_zero: vld=%b res=%h zero=%b, want 1 0 1", bus.rsp_valid, bus.result, bus.zero);
    end
    consume();
    send(4'b0110, 64'd0, 64'd1);
    tests++;
    if (bus.rsp_valid !== 1'b1 || bus.result !== 64'hFFFF_FFFF_FFFF_FFFF || bus.zero !== 1'b0) begin
      fails++;
      $display("FAIL sub_wrap: vld=%b res=%h zero=%b, want 1 ffffffffffffffff 0",
               bus.rsp_valid, bus.result, bus.zero);
    end
    consume();
  endtask

  task automatic test_single_ops();
    logic [3:0]   ops [6] = '{4'b0000, 4'b0001, 4'b0111, 4'b1100, 4'b1111, 4'b0011};
    logic [N-1:0] av  [6] = '{64'hF0F0, 64'hF000_0000_0000_000F, 64'hDEAD, 64'h0F, 64'd3, 64'd9};
    logic [N-1:0] bv  [6] = '{64'h3C3C, 64'h0F0, 64'h1234_5678_9ABC_DEF0, 64'hF0, 64'd4, 64'd7};
    logic [N-1:0] ex  [6] = '{64'h3030, 64'hF000_0000_0000_00FF, 64'h1234_5678_9ABC_DEF0,
                              64'hFFFF_FFFF_FFFF_FF00, 64'h0, 64'h0};
    logic         ez  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      send(ops[i], av[i], bv[i]);
      tests++;
      if (bus.rsp_valid !== 1'b1 || bus.result !== ex[i] || bus.zero !== ez[i]) begin
        fails++;
        $display("FAIL single_op[%0d] op=%b: vld=%b res=%h zero=%b, want 1 %h %b",
                 i, ops[i], bus.rsp_valid, bus.result, bus.zero, ex[i], ez[i]);
      end
      consume();
    end
  endtask

  task automatic mul_check(input logic [N-1:0] av, input logic [N-1:0] bv,
                           input logic [N-1:0] exp_res, input logic exp_zero);
    int bad_cycles = 0;
    send(4'b1000, av, bv);
    // Inputs during MUL must be ignored and operands must stay latched.
    bus.req_valid = 1'b1; bus.ALUControl = 4'b0001; bus.a = '1; bus.b = '1;
    for (int i = 0; i < 64; i++) begin
      if (bus.busy !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0) bad_cycles++;
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    tests++;
    if (bad_cycles != 0) begin
      fails++;
      $display("FAIL mul_busy_window: %0d bad cycles of 64, want 0", bad_cycles);
    end
    tests++;
    if (bus.rsp_valid !== 1'b1 || bus.busy !== 1'b0 || bus.result !== exp_res || bus.zero !== exp_zero) begin
      fails++;
      $display("FAIL mul_result: vld=%b busy=%b res=%h zero=%b, want 1 0 %h %b",
               bus.rsp_valid, bus.busy, bus.result, bus.zero, exp_res, exp_zero);
    end
    consume();
  endtask

  task automatic test_mul();
    mul_check(64'h1_0000_0000, 64'h1_0000_0003, 64'h0000_0003_0000_0000, 1'b0);
    mul_check(64'h8000_0000_0000_0000, 64'd2, 64'h0, 1'b1);
    mul_check(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
  endtask

  task automatic test_backpressure();
    int bad_cycles = 0;
    send(4'b1100, 64'h0, 64'h0);
    bus.req_valid = 1'b1; bus.ALUControl = 4'b0000; bus.a = '0; bus.b = '0;
    for (int i = 0; i < 10; i++) begin
      if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0 ||
          bus.result !== 64'hFFFF_FFFF_FFFF_FFFF || bus.zero !== 1'b0) bad_cycles++;
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    tests++;
    if (bad_cycles != 0) begin
      fails++;
      $display("FAIL backpressure_hold: %0d bad cycles of 10, want 0", bad_cycles);
    end
    consume();
    send(4'b0000, 64'hF, 64'h3);
    tests++;
    if (bus.rsp_valid !== 1'b1 || bus.result !== 64'h3 || bus.zero !== 1'b0) begin
      fails++;
      $display("FAIL back_to_back: vld=%b res=%h zero=%b, want 1 3 0", bus.rsp_valid, bus.result, bus.zero);
    end
    consume();
  endtask

  task automatic test_reset_mid_mul();
    send(4'b1000, 64'h1_0000_0000, 64'h1_0000_0003);
    repeat (29) begin @(posedge clk); #1; end
    tests++;
    if (bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL mul_cycle30_busy: busy=%b, want 1", bus.busy);
    end
    #2 reset = 1'b0;
    #1;
    tests++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.result !== 64'h0 || bus.zero !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: rdy=%b vld=%b busy=%b res=%h zero=%b, want 1 0 0 0 0",
               bus.req_ready, bus.rsp_valid, bus.busy, bus.result, bus.zero);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    send(4'b0000, 64'hF0, 64'h3C);
    tests++;
    if (bus.rsp_valid !== 1'b1 || bus.result !== 64'h30 || bus.zero !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_and: vld=%b res=%h zero=%b, want 1 30 0", bus.rsp_valid, bus.result, bus.zero);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_single_ops();
    test_mul();
    test_backpressure();
    test_reset_mid_mul();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
